// File: rtl/mips_trace_buffer.sv
// Pipeline trace buffer: cycle-stamped capture records in a circular buffer, drained over valid/ready.
// Defining TRACE_DROP_COUNT_EN adds the saturating dropped_count port.
module mips_trace_buffer #(
    parameter int  DEPTH      = 16,
    parameter int  PC_W       = 32,
    parameter int  DATA_W     = 32,
    parameter int  CYC_W      = 16,
    parameter int  STOP_CYCLE = 0,
    parameter int  WRAP       = 1,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1,
    localparam int REC_W      = CYC_W + PC_W + 32 + 1 + 5 + DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_valid,
    input  logic [PC_W-1:0]   cap_pc,
    input  logic [31:0]       cap_instr,
    input  logic              cap_wb_reg_write,
    input  logic [4:0]        cap_wb_dest,
    input  logic [DATA_W-1:0] cap_wb_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [REC_W-1:0]  rd_record,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              halt,
    output logic              overflow
`ifdef TRACE_DROP_COUNT_EN
    ,
    output logic [CYC_W-1:0]  dropped_count
`endif
);

    localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] STOP_C  = CYC_W'(STOP_CYCLE);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic             write_en;
    logic             lose;
    logic [CYC_W-1:0] cycle_next;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign rd_valid  = !empty;
    assign rd_record = mem[rd_ptr];

    // A full buffer accepts a push when a pop frees the head slot, or when wrapping overwrites it.
    always_comb begin
        do_push    = cap_valid && !halt;
        do_pop     = rd_valid && rd_ready;
        write_en   = do_push && (!full || do_pop || (WRAP != 0));
        lose       = do_push && full && !do_pop;
        cycle_next = (cycle_count == CYC_MAX) ? cycle_count : cycle_count + CYC_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cycle_count <= '0;
            halt        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (write_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop || (lose && (WRAP != 0)))
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (write_en && !do_pop && !full)
                count <= count + CNT_W'(1);
            else if (do_pop && !write_en)
                count <= count - CNT_W'(1);
            if (lose)
                overflow <= 1'b1;
            cycle_count <= cycle_next;
            // Set one edge early so halt is already high in the STOP_CYCLE cycle.
            if ((STOP_CYCLE != 0) && (cycle_next == STOP_C))
                halt <= 1'b1;
        end
    end

    // NOTE: the record store has no reset; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (write_en && !reset)
            mem[wr_ptr] <= {cycle_count, cap_pc, cap_instr, cap_wb_reg_write, cap_wb_dest, cap_wb_data};
    end

`ifdef TRACE_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            dropped_count <= '0;
        else if ((lose || (cap_valid && halt)) && (dropped_count != CYC_MAX))
            dropped_count <= dropped_count + CYC_W'(1);
    end
`else
    // Without the counter, overflow is the only loss indication.
`endif

endmodule
